mux_rr_sched: RTL

Round-robin scheduler that shares the 8:1 single-bit multiplexer between eight requesters. Each requester raises its request line; the block grants one requester at a time, drives the 3-bit mux select for the holder, and bounds each ownership burst so no requester can starve the others. The block sits directly in front of the 8:1 mux: its `sel` output feeds the mux select, and its gated `y` output is the shared data path seen downstream.

---
 rtl/mux_rr_sched_if.sv | 11 +
 rtl/mux_rr_sched.sv | 66 ++++++
 2 files changed

// File: rtl/mux_rr_sched_if.sv
// mux_rr_sched_if: request/grant and shared mux data signals of the round-robin scheduler
interface mux_rr_sched_if;
    logic [7:0] req;
    logic [7:0] a;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;
    modport master (output req, a, input gnt, sel, busy, y);
    modport slave  (input req, a, output gnt, sel, busy, y);
endinterface

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin owner of an 8:1 mux with bounded bursts per grant
module mux_rr_sched #(
    parameter int BURST_MAX = 4
) (
    input logic           clk,
    input logic           rst,
    mux_rr_sched_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state, state_n;
    logic [2:0] ptr, ptr_n, sel_n, win, idx;
    logic [7:0] cnt, cnt_n, gnt_n;
    logic       any, rel;
    // scan from the highest offset down so the entry nearest ptr wins last
    always_comb begin
        win = ptr;
        any = 1'b0;
        idx = ptr;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (bus.req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end
    assign rel = !bus.req[bus.sel] || cnt == 8'(BURST_MAX);
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        sel_n   = bus.sel;
        gnt_n   = bus.gnt;
        if (state == IDLE || rel) begin
            if (any) begin
                state_n = GRANT;
                gnt_n   = 8'b1 << win;
                sel_n   = win;
                cnt_n   = 8'd1;
                ptr_n   = win + 3'd1;
            end else if (state == GRANT) begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        end else begin
            cnt_n = cnt + 8'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            bus.sel <= '0;
            bus.gnt <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            bus.sel <= sel_n;
            bus.gnt <= gnt_n;
        end
    end
    assign bus.busy = state == GRANT;
    assign bus.y    = bus.busy & bus.a[bus.sel];
endmodule
